// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential IEEE-754 divider.
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_t;

    localparam int FLG_INV = 3;
    localparam int FLG_DBZ = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; takes the magnitude (sign stripped) of an operand.
import fp_div_pkg::*;

module fp_classify #(
    parameter int N = 32,
    parameter int E = 8
) (
    input  logic [N-2:0] mag,
    output cls_t         cls
);

    localparam int F = N - E - 1;

    // Subnormals (exp=0) are folded into zero.
    always_comb begin
        if (mag[N-2:F] == '0)
            cls = CLS_ZERO;
        else if (mag[N-2:F] == '1)
            cls = (mag[F-1:0] == '0) ? CLS_INF : CLS_NAN;
        else
            cls = CLS_NORM;
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative restoring IEEE-754 divider, one quotient bit per cycle, valid/ready on both sides.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise truncation with max-finite on overflow.
import fp_div_pkg::*;

module fp_div_seq #(
    parameter int N = 32,
    parameter int E = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int F    = N - E - 1;
    localparam int BIAS = 2**(E-1) - 1;
    localparam int EW   = E + 2;
    localparam int CW   = $clog2(F + 3);

    localparam logic [CW-1:0]        CNT_LAST = CW'(F + 2);
    localparam logic signed [EW-1:0] EXP_INF  = EW'(2**E - 1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_BIAS = EW'(BIAS);
    localparam logic [N-1:0]         QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    state_t                 state;
    cls_t                   cls_a, cls_b;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_r;
    logic [F:0]             mb_r;
    logic [F+1:0]           rem_r;
    logic [F+2:0]           q_r;
    logic [CW-1:0]          cnt_r;

    logic                   sgn;
    logic signed [EW-1:0]   exp_acc;
    logic                   spec_hit;
    logic [N-1:0]           spec_res;
    logic [3:0]             spec_flg;

    logic                   ge;
    logic [F+1:0]           rem_sub;
    logic [F+1:0]           rem_next;

    logic signed [EW-1:0]   exp_t, exp_f;
    logic [F-1:0]           frac_t, frac_f;
    logic [N-1:0]           norm_res;
    logic [3:0]             norm_flg;

    assign in_ready = (state == ST_IDLE) && rst_n;

    fp_classify #(.N(N), .E(E)) u_cls_a (.mag(a[N-2:0]), .cls(cls_a));
    fp_classify #(.N(N), .E(E)) u_cls_b (.mag(b[N-2:0]), .cls(cls_b));

    assign sgn     = a[N-1] ^ b[N-1];
    assign exp_acc = $signed({2'b00, a[N-2:F]}) - $signed({2'b00, b[N-2:F]}) + EXP_BIAS;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            spec_res = QNAN;
        end else if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
            spec_res = QNAN;
            spec_flg[FLG_INV] = 1'b1;
        end else if (cls_a == CLS_INF) begin
            spec_res = {sgn, {E{1'b1}}, {F{1'b0}}};
        end else if (cls_b == CLS_ZERO) begin
            spec_res = {sgn, {E{1'b1}}, {F{1'b0}}};
            spec_flg[FLG_DBZ] = 1'b1;
        end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
            spec_res = {sgn, {(N-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // rem stays below 2*mb, so the subtracted value always fits in F+1 bits before the shift.
    always_comb begin
        ge       = (rem_r >= {1'b0, mb_r});
        rem_sub  = ge ? (rem_r - {1'b0, mb_r}) : rem_r;
        rem_next = {rem_sub[F:0], 1'b0};
    end

`ifdef FP_DIV_RNE_EN
    logic       guard, sticky;
    logic [F:0] frac_sum;
`endif

    always_comb begin
        if (q_r[F+2]) begin
            frac_t = q_r[F+1:2];
            exp_t  = exp_r;
        end else begin
            frac_t = q_r[F:1];
            exp_t  = exp_r - EXP_ONE;
        end
        frac_f = frac_t;
        exp_f  = exp_t;
`ifdef FP_DIV_RNE_EN
        if (q_r[F+2]) begin
            guard  = q_r[1];
            sticky = q_r[0] | (rem_r != '0);
        end else begin
            guard  = q_r[0];
            sticky = (rem_r != '0);
        end
        frac_sum = {1'b0, frac_t} + {{F{1'b0}}, guard & (sticky | frac_t[0])};
        frac_f   = frac_sum[F-1:0];
        if (frac_sum[F])
            exp_f = exp_t + EXP_ONE;
`endif
        norm_flg = '0;
        norm_res = {sign_r, exp_f[E-1:0], frac_f};
        if (exp_f >= EXP_INF) begin
            norm_flg[FLG_OVF] = 1'b1;
`ifdef FP_DIV_RNE_EN
            norm_res = {sign_r, {E{1'b1}}, {F{1'b0}}};
`else
            norm_res = {sign_r, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
`endif
        end else if (exp_f < EXP_ONE) begin
            norm_flg[FLG_UNF] = 1'b1;
            norm_res = {sign_r, {(N-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mb_r      <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            cnt_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_r <= sgn;
                        exp_r  <= exp_acc;
                        mb_r   <= {1'b1, b[F-1:0]};
                        rem_r  <= {2'b01, a[F-1:0]};
                        q_r    <= '0;
                        cnt_r  <= '0;
                        if (spec_hit) begin
                            result <= spec_res;
                            flags  <= spec_flg;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_next;
                    q_r   <= {q_r[F+1:0], ge};
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST)
                        state <= ST_NORM;
                end
                ST_NORM: begin
                    result <= norm_res;
                    flags  <= norm_flg;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    // out_valid rises one cycle after entry, giving both paths a common timing.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq (32-bit and 16-bit instances).
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.N(32), .E(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_div_seq #(.N(16), .E(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int w;
        @(negedge clk);
        a = xa; b = xb; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        f = flags;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs: got ov=%b res=%h flg=%b, want ov=0 res=0 flg=0", out_valid, result, flags);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] va [3] = '{32'h40C00000, 32'hC0C00000, 32'h3F800000};
        logic [31:0] vb [3] = '{32'h40000000, 32'h40000000, 32'h3F800000};
        logic [31:0] vr [3] = '{32'h40400000, 32'hC0400000, 32'h3F800000};
        logic [31:0] r;
        logic [3:0]  f;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], r, f, lat);
            checks++;
            if (r !== vr[i] || f !== 4'b0000) begin
                failures++;
                $display("FAIL basic_%0d: got res=%h flg=%b, want res=%h flg=0000", i, r, f, vr[i]);
            end
            checks++;
            if (lat !== 28) begin
                failures++;
                $display("FAIL basic_latency_%0d: got %0d want 28", i, lat);
            end
            consume();
        end
    endtask

    task automatic test_rounding();
        logic [31:0] r;
        logic [3:0]  f;
        int lat;
        logic [31:0] exp_third, exp_near1;
`ifdef FP_DIV_RNE_EN
        exp_third = 32'h3EAAAAAB;
        exp_near1 = 32'h3F800001;
`else
        exp_third = 32'h3EAAAAAA;
        exp_near1 = 32'h3F800000;
`endif
        run_op(32'h3F800000, 32'h40400000, r, f, lat);
        checks++;
        if (r !== exp_third || f !== 4'b0000) begin
            failures++;
            $display("FAIL round_one_third: got res=%h flg=%b, want res=%h flg=0000", r, f, exp_third);
        end
        checks++;
        if (lat !== 28) begin
            failures++;
            $display("FAIL round_latency: got %0d want 28", lat);
        end
        consume();
        run_op(32'h3F7FFFFF, 32'h3F7FFFFE, r, f, lat);
        checks++;
        if (r !== exp_near1 || f !== 4'b0000) begin
            failures++;
            $display("FAIL round_near_one: got res=%h flg=%b, want res=%h flg=0000", r, f, exp_near1);
        end
        consume();
    endtask

    task automatic test_special();
        logic [31:0] va [8] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00001,
                                32'hFF800000, 32'h3F800000, 32'h80000000, 32'h00400000};
        logic [31:0] vb [8] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000,
                                32'h40000000, 32'hFF800000, 32'h3F800000, 32'h3F800000};
        logic [31:0] vr [8] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                32'hFF800000, 32'h80000000, 32'h80000000, 32'h00000000};
        logic [3:0]  vf [8] = '{4'b0100, 4'b1000, 4'b1000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] r;
        logic [3:0]  f;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], r, f, lat);
            checks++;
            if (r !== vr[i] || f !== vf[i] || lat !== 1) begin
                failures++;
                $display("FAIL special_%0d: got res=%h flg=%b lat=%0d, want res=%h flg=%b lat=1",
                         i, r, f, lat, vr[i], vf[i]);
            end
            consume();
        end
    endtask

    task automatic test_range();
        logic [31:0] r;
        logic [3:0]  f;
        int lat;
        logic [31:0] exp_ovf;
`ifdef FP_DIV_RNE_EN
        exp_ovf = 32'h7F800000;
`else
        exp_ovf = 32'h7F7FFFFF;
`endif
        run_op(32'h7F000000, 32'h3E800000, r, f, lat);
        checks++;
        if (r !== exp_ovf || f !== 4'b0010) begin
            failures++;
            $display("FAIL overflow: got res=%h flg=%b, want res=%h flg=0010", r, f, exp_ovf);
        end
        consume();
        run_op(32'h00800000, 32'h40000000, r, f, lat);
        checks++;
        if (r !== 32'h00000000 || f !== 4'b0001) begin
            failures++;
            $display("FAIL underflow: got res=%h flg=%b, want res=00000000 flg=0001", r, f);
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic [3:0]  f;
        int lat;
        int bad;
        run_op(32'h40C00000, 32'h40000000, r, f, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
            if (result !== 32'h40400000 || flags !== 4'b0000 || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold_in_done: got %0d bad cycles, want 0 (res=%h ov=%b ir=%b)", bad, result, out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
        run_op(32'h40800000, 32'h40000000, r, f, lat);
        checks++;
        if (r !== 32'h40000000 || lat !== 28) begin
            failures++;
            $display("FAIL after_release_op: got res=%h lat=%0d, want res=40000000 lat=28", r, lat);
        end
        consume();
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: got ir=%b ov=%b, want ir=1 ov=0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_output: got %0d valid cycles, want 0", seen);
        end
    endtask

    task automatic test_half();
        logic [15:0] va [2] = '{16'h4600, 16'h3C00};
        logic [15:0] vb [2] = '{16'h4000, 16'h4000};
        logic [15:0] vr [2] = '{16'h4200, 16'h3800};
        int lat;
        int w;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            h_a = va[i]; h_b = vb[i]; h_in_valid = 1'b1;
            w = 0;
            while (!h_in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            @(posedge clk);
            #1 h_in_valid = 1'b0;
            lat = 0;
            while (!h_out_valid && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (h_result !== vr[i] || h_flags !== 4'b0000 || lat !== 15) begin
                failures++;
                $display("FAIL half_%0d: got res=%h flg=%b lat=%0d, want res=%h flg=0000 lat=15",
                         i, h_result, h_flags, lat, vr[i]);
            end
            h_out_ready = 1'b1;
            @(posedge clk);
            #1 h_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_special();
        test_range();
        test_backpressure();
        test_abort();
        test_half();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
